// File: rtl/window_gen_pkg.sv
// Shared types for the window index generator: sweep state encoding.
package window_gen_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/window_mod_add.sv
// Modular adder: (a + b) mod SIZE for operands already below SIZE,
// using one conditional subtract on the W+1-bit sum.
module window_mod_add #(
    parameter int SIZE = 16,
    parameter int W    = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    localparam logic [W:0] SIZE_X = (W+1)'(SIZE);

    logic [W:0] raw_s;
    logic [W:0] wrap_s;

    assign raw_s  = {1'b0, a} + {1'b0, b};
    assign wrap_s = raw_s - SIZE_X;

    // Fold the sum back into range when it reaches SIZE.
    always_comb begin
        if (raw_s >= SIZE_X) begin
            sum = wrap_s[W-1:0];
        end else begin
            sum = raw_s[W-1:0];
        end
    end

endmodule

// File: rtl/window_index_gen.sv
// Streams beats_in windows of K modulo-SIZE indices over valid/ready.
// Define WINDOW_GEN_STRIDE_EN to add the stride_in port (otherwise stride is 1).
module window_index_gen
    import window_gen_pkg::*;
#(
    parameter  int SIZE      = 16,
    parameter  int K         = 4,
    parameter  int MAX_BEATS = 256,
    localparam int W         = $clog2(SIZE),
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    base_in,
    input  logic [W-1:0]    step_in,
    input  logic [CW-1:0]   beats_in,
`ifdef WINDOW_GEN_STRIDE_EN
    input  logic [W-1:0]    stride_in,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W*K-1:0]  num_out,
    output logic [CW-1:0]   beat_idx,
    output logic            busy,
    output logic            done
);

    localparam logic [W:0] SIZE_X = (W+1)'(SIZE);

    // Inputs span 0..2^W-1 < 2*SIZE, so one subtract is enough.
    function automatic logic [W-1:0] mod_reduce(input logic [W-1:0] x);
        logic [W:0] xe;
        logic [W:0] xw;
        xe = {1'b0, x};
        xw = xe - SIZE_X;
        if (xe >= SIZE_X) begin
            return xw[W-1:0];
        end else begin
            return x;
        end
    endfunction

    state_t         state_r, state_n;
    logic [W-1:0]   base_r, base_n;
    logic [W-1:0]   step_r, step_n;
    logic [W-1:0]   stride_r, stride_n;
    logic [CW-1:0]  beats_r, beats_n;
    logic [CW-1:0]  beat_idx_r, beat_idx_n;
    logic [W*K-1:0] num_out_r, num_out_n;
    logic           out_valid_r, out_valid_n;
    logic           busy_r, busy_n;
    logic           done_r, done_n;

    logic [W-1:0]   base_red_s, step_red_s, stride_red_s;
    logic [W-1:0]   base_next_s, chain_stride_s;
    logic [W-1:0]   lane_s [K];
    logic [W*K-1:0] window_s;
    logic [CW-1:0]  idx_inc_s;
    logic           accept_s;

    assign base_red_s = mod_reduce(base_in);
    assign step_red_s = mod_reduce(step_in);
`ifdef WINDOW_GEN_STRIDE_EN
    assign stride_red_s = mod_reduce(stride_in);
`else
    assign stride_red_s = W'(1'b1);
`endif

    window_mod_add #(.SIZE(SIZE), .W(W)) u_base_add (
        .a   (base_r),
        .b   (step_r),
        .sum (base_next_s)
    );

    // In IDLE the chain builds window 0 from the fresh inputs; in RUN the next window.
    assign lane_s[0]      = (state_r == ST_IDLE) ? base_red_s : base_next_s;
    assign chain_stride_s = (state_r == ST_IDLE) ? stride_red_s : stride_r;

    for (genvar i = 1; i < K; i++) begin : g_lane
        window_mod_add #(.SIZE(SIZE), .W(W)) u_lane_add (
            .a   (lane_s[i-1]),
            .b   (chain_stride_s),
            .sum (lane_s[i])
        );
    end

    for (genvar i = 0; i < K; i++) begin : g_pack
        assign window_s[W*(i+1)-1 -: W] = lane_s[i];
    end

    assign accept_s  = out_valid_r & out_ready;
    assign idx_inc_s = beat_idx_r + CW'(1);

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_n     = state_r;
        base_n      = base_r;
        step_n      = step_r;
        stride_n    = stride_r;
        beats_n     = beats_r;
        beat_idx_n  = beat_idx_r;
        num_out_n   = num_out_r;
        out_valid_n = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    base_n     = base_red_s;
                    step_n     = step_red_s;
                    stride_n   = stride_red_s;
                    beats_n    = beats_in;
                    beat_idx_n = CW'(0);
                    busy_n     = 1'b1;
                    if (beats_in == CW'(0)) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n     = ST_RUN;
                        out_valid_n = 1'b1;
                        num_out_n   = window_s;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_n      = 1'b1;
                out_valid_n = 1'b1;
                if (accept_s) begin
                    if (idx_inc_s == beats_r) begin
                        state_n     = ST_DONE;
                        out_valid_n = 1'b0;
                        done_n      = 1'b1;
                    end else begin
                        base_n     = base_next_s;
                        beat_idx_n = idx_inc_s;
                        num_out_n  = window_s;
                    end
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            base_r      <= W'(0);
            step_r      <= W'(0);
            stride_r    <= W'(0);
            beats_r     <= CW'(0);
            beat_idx_r  <= CW'(0);
            num_out_r   <= (W*K)'(0);
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            base_r      <= base_n;
            step_r      <= step_n;
            stride_r    <= stride_n;
            beats_r     <= beats_n;
            beat_idx_r  <= beat_idx_n;
            num_out_r   <= num_out_n;
            out_valid_r <= out_valid_n;
            busy_r      <= busy_n;
            done_r      <= done_n;
        end
    end

    assign out_valid = out_valid_r;
    assign num_out   = num_out_r;
    assign beat_idx  = beat_idx_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_window_index_gen.sv
// Randomized bench: two instances (SIZE=16 and SIZE=10, K=4) on shared stimulus,
// checked against a per-sweep arithmetic model of the expected windows.
module tb_window_index_gen;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic        start_s;
    logic [3:0]  base_in_s, step_in_s, stride_in_s;
    logic [8:0]  beats_in_s;
    logic        out_ready_s;
    logic        valid_a_s, valid_b_s, busy_a_s, busy_b_s, done_a_s, done_b_s;
    logic [15:0] num_a_s, num_b_s;
    logic [8:0]  idx_a_s, idx_b_s;

    int checks = 0;
    int errors = 0;

    always #5 clk_s = ~clk_s;

    window_index_gen #(.SIZE(16), .K(4), .MAX_BEATS(256)) dut_a (
        .clk(clk_s), .rst(rst_s), .start(start_s),
        .base_in(base_in_s), .step_in(step_in_s), .beats_in(beats_in_s),
`ifdef WINDOW_GEN_STRIDE_EN
        .stride_in(stride_in_s),
`endif
        .out_valid(valid_a_s), .out_ready(out_ready_s), .num_out(num_a_s),
        .beat_idx(idx_a_s), .busy(busy_a_s), .done(done_a_s)
    );

    window_index_gen #(.SIZE(10), .K(4), .MAX_BEATS(256)) dut_b (
        .clk(clk_s), .rst(rst_s), .start(start_s),
        .base_in(base_in_s), .step_in(step_in_s), .beats_in(beats_in_s),
`ifdef WINDOW_GEN_STRIDE_EN
        .stride_in(stride_in_s),
`endif
        .out_valid(valid_b_s), .out_ready(out_ready_s), .num_out(num_b_s),
        .beat_idx(idx_b_s), .busy(busy_b_s), .done(done_b_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Window j of a sweep: lane i = (base + j*step + i*stride) mod size.
    function automatic logic [15:0] exp_window(input int size, input int base, input int step,
                                               input int stride, input int j);
        logic [15:0] w;
        int b;
        int st;
        int lane;
`ifdef WINDOW_GEN_STRIDE_EN
        st = stride % size;
`else
        st = 1;
`endif
        b = (base % size + j * (step % size)) % size;
        w = 16'h0;
        for (int i = 0; i < 4; i++) begin
            lane = (b + i * st) % size;
            w[4*i +: 4] = lane[3:0];
        end
        return w;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_valid_a"}, 32'(valid_a_s), 32'd0);
        chk({tag, "_valid_b"}, 32'(valid_b_s), 32'd0);
        chk({tag, "_busy_a"},  32'(busy_a_s),  32'd0);
        chk({tag, "_busy_b"},  32'(busy_b_s),  32'd0);
        chk({tag, "_done_a"},  32'(done_a_s),  32'd0);
        chk({tag, "_done_b"},  32'(done_b_s),  32'd0);
    endtask

    // One sweep; abort_beat >= 0 applies reset while window abort_beat is on offer.
    task automatic run_sweep(input int base, input int step, input int stride, input int beats,
                             input int ready_pct, input int abort_beat);
        int j;
        int cyc;
        logic rdy;
        @(negedge clk_s);
        base_in_s   = 4'(base);
        step_in_s   = 4'(step);
        stride_in_s = 4'(stride);
        beats_in_s  = 9'(beats);
        start_s     = 1'b1;
        out_ready_s = 1'b0;
        @(negedge clk_s);
        j = 0;
        cyc = 0;
        while (j < beats && cyc < 4000) begin
            if (j == abort_beat) begin
                start_s = 1'b0;
                rst_s   = 1'b1;
                @(negedge clk_s);
                rst_s = 1'b0;
                chk("abort_num_a", 32'(num_a_s), 32'd0);
                chk("abort_num_b", 32'(num_b_s), 32'd0);
                chk("abort_idx_a", 32'(idx_a_s), 32'd0);
                chk_idle("abort");
                @(negedge clk_s);
                chk_idle("abort_after");
                return;
            end
            chk("valid_a", 32'(valid_a_s), 32'd1);
            chk("valid_b", 32'(valid_b_s), 32'd1);
            chk("num_a", 32'(num_a_s), 32'(exp_window(16, base, step, stride, j)));
            chk("num_b", 32'(num_b_s), 32'(exp_window(10, base, step, stride, j)));
            chk("idx_a", 32'(idx_a_s), 32'(j));
            chk("idx_b", 32'(idx_b_s), 32'(j));
            chk("busy_run", 32'(busy_a_s & busy_b_s), 32'd1);
            chk("done_run", 32'(done_a_s | done_b_s), 32'd0);
            rdy = ($urandom_range(99) < 32'(ready_pct));
            out_ready_s = rdy;
            start_s     = 1'($urandom);
            base_in_s   = 4'($urandom);
            step_in_s   = 4'($urandom);
            stride_in_s = 4'($urandom);
            beats_in_s  = 9'($urandom);
            @(negedge clk_s);
            if (rdy) j++;
            cyc++;
        end
        chk("done_a", 32'(done_a_s), 32'd1);
        chk("done_b", 32'(done_b_s), 32'd1);
        chk("done_valid", 32'(valid_a_s | valid_b_s), 32'd0);
        chk("done_busy", 32'(busy_a_s & busy_b_s), 32'd1);
        start_s = 1'b1;
        out_ready_s = 1'b0;
        @(negedge clk_s);
        start_s = 1'b0;
        chk_idle("post_done");
        @(negedge clk_s);
        chk_idle("start_in_done_ignored");
    endtask

    initial begin
        rst_s = 1'b1;
        start_s = 1'b0;
        out_ready_s = 1'b0;
        base_in_s = 4'd0;
        step_in_s = 4'd0;
        stride_in_s = 4'd0;
        beats_in_s = 9'd0;
        repeat (3) @(negedge clk_s);
        chk("reset_num_a", 32'(num_a_s), 32'd0);
        chk("reset_idx_a", 32'(idx_a_s), 32'd0);
        chk_idle("reset");
        rst_s = 1'b0;

        run_sweep(14, 1, 1, 3, 100, -1);
        run_sweep(14, 1, 1, 3, 40, -1);
        run_sweep(15, 3, 1, 2, 100, -1);
        run_sweep(9, 5, 3, 0, 100, -1);
        run_sweep(14, 2, 4, 2, 100, -1);
        run_sweep(14, 1, 1, 3, 100, 1);
        run_sweep(14, 1, 1, 3, 100, -1);
        run_sweep(3, 7, 6, 40, 70, -1);
        for (int n = 0; n < 25; n++) begin
            run_sweep(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
                      int'($urandom_range(12)), int'($urandom_range(100, 30)),
                      ($urandom_range(5) == 0) ? int'($urandom_range(3)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
